// File: rtl/prio_encoder_rr_pkg.sv
// rtl/prio_encoder_rr_pkg.sv - shared modes and width helper for prio_encoder_rr
package prio_encoder_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for an n-wide request vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_encoder_rr_pick.sv
// rtl/prio_encoder_rr_pick.sv - combinational highest-set / wrapped lowest-from-base search
//
// Ports:
//   vector  N-bit request vector
//   base    search start index for the wrapped search
//   dir     MODE_FIXED: highest set bit; MODE_RR: lowest set bit at index >= base,
//           else lowest set bit overall
//   idx     picked index (0 when nothing is set)
//   onehot  one-hot of idx (all zero when nothing is set)
//   found   at least one bit of vector is set
module prio_pick
  import prio_encoder_rr_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] vector,
  input  logic [W-1:0] base,
  input  logic         dir,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         found
);

  logic [W-1:0] low_idx;
  logic [W-1:0] hit_idx;
  logic [W-1:0] high_idx;
  logic         hit;

  always_comb begin
    low_idx  = '0;
    hit_idx  = '0;
    high_idx = '0;
    hit      = 1'b0;
    // Scanning downward leaves the lowest match in place; scanning upward the highest.
    for (int i = N - 1; i >= 0; i--) begin
      if (vector[i]) begin
        low_idx = W'(i);
        if (i >= int'(base)) begin
          hit     = 1'b1;
          hit_idx = W'(i);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (vector[i]) high_idx = W'(i);
    end
  end

  always_comb begin
    found  = |vector;
    idx    = '0;
    onehot = '0;
    if (found) begin
      if (dir == MODE_FIXED) idx = high_idx;
      else                   idx = hit ? hit_idx : low_idx;
      onehot = N'(1) << idx;
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// rtl/prio_encoder_rr.sv - registered fixed/round-robin priority encoder with valid/ready output
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   en           capture enable
//   mode         0 fixed priority (highest index), 1 round-robin
//   req          N-bit request vector
//   out_ready    consumer accepts the output register
//   out_valid    output register holds a grant
//   out_idx      granted index
//   out_onehot   one-hot of out_idx, zero when out_valid is 0
//   any_req      combinational en & |req
module prio_encoder_rr
  import prio_encoder_rr_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         any_req
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] ptr;
  logic [W-1:0] pick_idx;
  logic [N-1:0] pick_onehot;
  logic         pick_found;
  logic         handshake;
  logic         load;

  assign handshake = out_valid & out_ready;
  assign load      = en & (~out_valid | out_ready);
  assign any_req   = en & (|req);

  prio_pick #(.N(N), .W(W)) u_pick (
    .vector (req),
    .base   (ptr),
    .dir    (mode),
    .idx    (pick_idx),
    .onehot (pick_onehot),
    .found  (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      ptr        <= '0;
    end else begin
      // ptr follows the departing grant; a same-cycle load still searched from the old ptr.
      if (handshake) ptr <= (out_idx == LAST) ? '0 : out_idx + 1'b1;
      if (load) begin
        out_valid  <= pick_found;
        out_idx    <= pick_idx;
        out_onehot <= pick_onehot;
      end else if (handshake) begin
        out_valid  <= 1'b0;
        out_idx    <= '0;
        out_onehot <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb/tb_prio_encoder_rr.sv - table-driven scoreboard bench for prio_encoder_rr (N=8 and N=6)
module tb_prio_encoder_rr;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic       rdy;
    logic       ev;
    logic [3:0] eidx;
    logic [3:0] eptr;
  } vec_t;

  typedef struct packed {
    logic        v;
    logic [5:0]  idx;
    logic [63:0] oh;
    logic [5:0]  ptr;
  } exp_t;

  logic clk;
  logic rst, en, mode, rdy;
  logic [7:0] req;

  logic       v8, any8;
  logic [2:0] idx8;
  logic [7:0] oh8;
  logic       v6, any6;
  logic [2:0] idx6;
  logic [5:0] oh6;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t tbl8[$];
  vec_t tbl6[$];

  prio_encoder_rr #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req), .out_ready(rdy),
    .out_valid(v8), .out_idx(idx8), .out_onehot(oh8), .any_req(any8)
  );

  prio_encoder_rr #(.N(6)) dut6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req[5:0]), .out_ready(rdy),
    .out_valid(v6), .out_idx(idx6), .out_onehot(oh6), .any_req(any6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic r, input logic e, input logic m, input logic [7:0] q,
                              input logic rd, input logic ev, input int ei, input int ep);
    vec_t t;
    t.rst = r; t.en = e; t.mode = m; t.req = q; t.rdy = rd;
    t.ev = ev; t.eidx = 4'(ei); t.eptr = 4'(ep);
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one vector on the falling edge, queue its expectation, compare after the next rising edge.
  task automatic step(input vec_t t, input bit six, input int n);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = t.rst; en = t.en; mode = t.mode; req = t.req; rdy = t.rdy;
    e.v   = t.ev;
    e.idx = 6'(t.eidx);
    e.oh  = t.ev ? (64'd1 << t.eidx) : 64'd0;
    e.ptr = 6'(t.eptr);
    sb.push_back(e);
    #1;
    if (six) chk($sformatf("any_req6[%0d]", n), {63'd0, any6}, {63'd0, t.en && (t.req[5:0] != 0)});
    else     chk($sformatf("any_req8[%0d]", n), {63'd0, any8}, {63'd0, t.en && (t.req != 0)});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      if (six) begin
        chk($sformatf("valid6[%0d]", n), {63'd0, v6}, {63'd0, got.v});
        chk($sformatf("idx6[%0d]", n), {61'd0, idx6}, {58'd0, got.idx});
        chk($sformatf("onehot6[%0d]", n), {58'd0, oh6}, got.oh);
        chk($sformatf("ptr6[%0d]", n), {61'd0, dut6.ptr}, {58'd0, got.ptr});
      end else begin
        chk($sformatf("valid8[%0d]", n), {63'd0, v8}, {63'd0, got.v});
        chk($sformatf("idx8[%0d]", n), {61'd0, idx8}, {58'd0, got.idx});
        chk($sformatf("onehot8[%0d]", n), {56'd0, oh8}, got.oh);
        chk($sformatf("ptr8[%0d]", n), {61'd0, dut8.ptr}, {58'd0, got.ptr});
      end
    end
  endtask

  initial begin
    int rr_idx[10];
    int rr_ptr[10];
    logic [7:0] stall_req[4];
    rr_idx = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4};
    rr_ptr = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5};
    stall_req = '{8'hFF, 8'h01, 8'h80, 8'h00};

    rst = 1'b1; en = 1'b0; mode = 1'b0; req = 8'h00; rdy = 1'b0;

    // N=8: fixed pick, then RR on all-ones (each grant repeats once since the load searches the old ptr).
    tbl8.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl8.push_back(mk(0, 1, 0, 8'h2C, 1, 1, 5, 0));
    tbl8.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) tbl8.push_back(mk(0, 1, 1, 8'hFF, 1, 1, rr_idx[i], rr_ptr[i]));
    // Grant 3, stall with toggling req, then release: ptr becomes 4.
    tbl8.push_back(mk(0, 1, 0, 8'h08, 1, 1, 3, 5));
    for (int i = 0; i < 4; i++) tbl8.push_back(mk(0, 1, 0, stall_req[i], 0, 1, 3, 5));
    tbl8.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 4));
    // RR from ptr 4, then drain with en=0.
    tbl8.push_back(mk(0, 1, 1, 8'h30, 1, 1, 4, 4));
    tbl8.push_back(mk(0, 0, 0, 8'hFF, 1, 0, 0, 5));
    tbl8.push_back(mk(0, 0, 0, 8'hFF, 1, 0, 0, 5));
    // Reset during a stalled grant, then RR wrap from index 7.
    tbl8.push_back(mk(0, 1, 0, 8'h40, 1, 1, 6, 5));
    tbl8.push_back(mk(0, 1, 0, 8'h01, 0, 1, 6, 5));
    tbl8.push_back(mk(1, 1, 0, 8'h01, 0, 0, 0, 0));
    tbl8.push_back(mk(0, 1, 1, 8'h80, 1, 1, 7, 0));
    tbl8.push_back(mk(0, 1, 1, 8'h80, 1, 1, 7, 0));
    // Mode change while stalled does not alter the held grant.
    tbl8.push_back(mk(0, 1, 1, 8'h03, 1, 1, 0, 0));
    tbl8.push_back(mk(0, 1, 0, 8'h03, 0, 1, 0, 0));
    tbl8.push_back(mk(0, 1, 0, 8'h03, 1, 1, 1, 1));

    // N=6: non-power-of-two wrap of the search and of ptr.
    tbl6.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl6.push_back(mk(0, 1, 0, 8'h10, 1, 1, 4, 0));
    tbl6.push_back(mk(0, 0, 1, 8'h06, 1, 0, 0, 5));
    tbl6.push_back(mk(0, 1, 1, 8'h06, 1, 1, 1, 5));
    tbl6.push_back(mk(0, 0, 1, 8'h06, 1, 0, 0, 2));
    tbl6.push_back(mk(0, 1, 1, 8'h21, 1, 1, 5, 2));
    tbl6.push_back(mk(0, 1, 1, 8'h21, 1, 1, 5, 0));
    tbl6.push_back(mk(0, 0, 1, 8'h21, 1, 0, 0, 0));
    tbl6.push_back(mk(0, 1, 1, 8'h21, 1, 1, 0, 0));

    foreach (tbl8[i]) step(tbl8[i], 1'b0, i);
    foreach (tbl6[i]) step(tbl6[i], 1'b1, i);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
